// File: rtl/melody_pkg.sv
// melody_pkg: shared widths, note half-period table and FSM states for the melody player.
package melody_pkg;
    localparam int NOTE_W = 3;
    localparam int ADDR_W = 6;
    localparam int HALF_W = 16;
    localparam logic [HALF_W-1:0] HALF_PERIOD [8] = '{
        16'd0, 16'd47778, 16'd42566, 16'd37921, 16'd35793, 16'd31888, 16'd28409, 16'd25310
    };
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY} state_t;
    function automatic logic [HALF_W-1:0] shifted_half(logic [NOTE_W-1:0] code, int shift);
        logic [HALF_W-1:0] h;
        h = HALF_PERIOD[code] >> shift;
        return (h == '0) ? HALF_W'(1) : h;
    endfunction
endpackage

// File: rtl/tone_gen.sv
// tone_gen: square wave that toggles every `half` cycles; held low while cleared or resting.
module tone_gen
    import melody_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              rest,
    input  logic [HALF_W-1:0] half,
    output logic              audio_out
);
    logic [HALF_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (reset || clear || rest) begin
            cnt       <= '0;
            audio_out <= 1'b0;
        end else if (cnt == half - 1'b1) begin
            cnt       <= '0;
            audio_out <= ~audio_out;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/melody_player.sv
// melody_player: walks the melody ROM, holds each note for NOTE_CYCLES and drives a square-wave pin.
module melody_player
    import melody_pkg::*;
#(
    parameter int NOTE_CYCLES = 6_250_000,
    parameter int MELODY_LEN  = 42,
    parameter int TONE_SHIFT  = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [NOTE_W-1:0] rom_q,
    output logic [NOTE_W-1:0] note,
    output logic              audio_out,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = $clog2(NOTE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  NOTE_LAST = CNT_W'(NOTE_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MELODY_LEN - 1);
    state_t            state;
    logic              fetch_2nd;
    logic [CNT_W-1:0]  note_cnt;
    logic [HALF_W-1:0] half;
    logic              note_end;
    logic              tone_clear;
    assign note_end   = (state == S_PLAY) && (note_cnt == NOTE_LAST);
    assign busy       = (state != S_IDLE);
    // tone is silenced on the edge that leaves PLAY so FETCH always sees audio low
    assign tone_clear = (state != S_PLAY) || stop || note_end;
    always_ff @(posedge clk) begin
        if (reset || stop) begin
            state     <= S_IDLE;
            fetch_2nd <= 1'b0;
            note_cnt  <= '0;
            rom_addr  <= '0;
            note      <= '0;
            half      <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    fetch_2nd <= 1'b0;
                    if (start) state <= S_FETCH;
                end
                S_FETCH: begin
                    fetch_2nd <= ~fetch_2nd;
                    if (fetch_2nd) begin
                        note     <= rom_q;
                        half     <= shifted_half(rom_q, TONE_SHIFT);
                        note_cnt <= '0;
                        state    <= S_PLAY;
                    end
                end
                S_PLAY: begin
                    note_cnt <= note_end ? '0 : note_cnt + 1'b1;
                    if (note_end) begin
                        if (rom_addr < ADDR_LAST) begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= S_FETCH;
                        end else if (loop) begin
                            rom_addr <= '0;
                            state    <= S_FETCH;
                        end else begin
                            rom_addr <= '0;
                            note     <= '0;
                            done     <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
    tone_gen u_tone (
        .clk       (clk),
        .reset     (reset),
        .clear     (tone_clear),
        .rest      (note == '0),
        .half      (half),
        .audio_out (audio_out)
    );
endmodule

// File: tb/tb_melody_player.sv
// tb_melody_player: random start/stop/loop/reset traffic checked cycle by cycle against a timeline model.
module tb_melody_player;
    localparam int NC  = 100;
    localparam int LEN = 42;
    localparam int SH  = 10;
    localparam int P   = NC + 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1, start = 1'b0, stop = 1'b0, loop = 1'b0;
    logic [5:0] rom_addr;
    logic [2:0] rom_q, note;
    logic       audio_out, busy, done;

    logic [2:0] mel [64];
    int half_tab [8] = '{0, 47778, 42566, 37921, 35793, 31888, 28409, 25310};

    int checks = 0, failures = 0;
    bit active = 0, done_exp = 0;
    int t = 0;
    int cyc = 0, start_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) rom_q <= mel[rom_addr];

    melody_player #(.NOTE_CYCLES(NC), .MELODY_LEN(LEN), .TONE_SHIFT(SH)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
        .rom_addr(rom_addr), .rom_q(rom_q), .note(note),
        .audio_out(audio_out), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // The model only tracks time since start; every output is derived from that position.
    task automatic step();
        int k, r, code, h, e_addr, e_note, e_aud;
        @(posedge clk);
        cyc++;
        done_exp = 0;
        if (reset || stop) active = 0;
        else if (!active) begin
            if (start) begin active = 1; t = 0; start_cyc = cyc; end
        end else begin
            t++;
            if (t % P == 0 && (t / P) % LEN == 0 && !loop) begin active = 0; done_exp = 1; end
        end
        #1;
        e_addr = 0; e_note = 0; e_aud = 0;
        if (active) begin
            k = t / P;
            r = t % P;
            e_addr = k % LEN;
            code = (r < 2) ? ((k == 0) ? 0 : int'(mel[(k - 1) % LEN])) : int'(mel[k % LEN]);
            e_note = code;
            if (r >= 2 && code != 0) begin
                h = half_tab[code] >> SH;
                if (h == 0) h = 1;
                e_aud = ((r - 2) / h) % 2;
            end
        end
        chk("rom_addr", int'(rom_addr), e_addr);
        chk("note", int'(note), e_note);
        chk("audio_out", int'(audio_out), e_aud);
        chk("busy", int'(busy), int'(active));
        chk("done", int'(done), int'(done_exp));
    endtask

    task automatic run(input int n, input int start_pm);
        for (int i = 0; i < n; i++) begin
            start = ($urandom_range(999) < start_pm);
            step();
        end
        start = 0;
    endtask

    task automatic wait_done(input int bound, output int seen);
        int n = 0;
        while (!done && n < bound) begin step(); n++; end
        seen = done;
    endtask

    initial begin
        int seen, lat;
        for (int i = 0; i < 64; i++) mel[i] = 3'($urandom_range(7));
        mel[0] = 3'd1;
        mel[3] = 3'd0;
        mel[20] = 3'd0;
        mel[41] = 3'd7;

        reset = 1; start = 1;
        repeat (3) step();
        reset = 0; start = 0;
        run(3, 0);

        loop = 0; start = 1; step(); start = 0;
        wait_done(4400, seen);
        lat = seen ? (cyc - start_cyc) : -1;
        chk("done_latency", lat, LEN * P);
        run(5, 0);

        loop = 1; start = 1; step(); start = 0;
        run(LEN * P + 300, 20);
        loop = 0;
        wait_done(LEN * P + 10, seen);
        chk("loop_then_done", seen, 1);
        run(5, 0);

        start = 1; step(); start = 0;
        run(17 * P + 50, 0);
        chk("mid_addr", int'(rom_addr), 17);
        stop = 1; step(); stop = 0;
        chk("stop_busy", int'(busy), 0);
        run(10, 0);
        start = 1; step(); start = 0;
        run(300, 0);

        reset = 1; step(); reset = 0;
        start = 1; step(); start = 0;
        run(17 * P + 60, 0);
        reset = 1; step(); reset = 0;
        chk("reset_busy", int'(busy), 0);
        start = 1; step(); start = 0;
        run(250, 0);

        reset = 1; step(); reset = 0;
        start = 1; stop = 1; step(); start = 0; stop = 0;
        chk("start_stop_idle", int'(busy), 0);

        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(49) == 0);
            stop  = ($urandom_range(399) == 0);
            loop  = 1'($urandom_range(1));
            reset = ($urandom_range(999) == 0);
            step();
        end
        start = 0; stop = 0; reset = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
